// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and register-index decode for the register slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index of a byte address; the two byte-lane bits are dropped.
  function automatic logic [3:0] addr_to_index(input logic [63:0] addr, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 4'((addr >> 2) & mask);
  endfunction

endpackage

// File: rtl/axi_lite_wr_join.sv
// Holds AW and W independently and fires a commit once both are present.
// Handshakes on the commit edge count as held, so AW+W together commit immediately.
module axi_lite_wr_join #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    block_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic                    commit_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o
);

  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                    aw_hs, w_hs;

  assign awready_o = !rst_i && !aw_held_q && !block_i;
  assign wready_o  = !rst_i && !w_held_q && !block_i;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;

  assign commit_o = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign addr_o   = aw_hs ? awaddr_i : addr_q;
  assign data_o   = w_hs ? wdata_i : data_q;
  assign strb_o   = w_hs ? wstrb_i : strb_q;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      addr_d    = awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      data_d   = wdata_i;
      strb_d   = wstrb_i;
    end
    if (commit_o) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes; out-of-range
// accesses answer SLVERR, and B and R are held until the master accepts them.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int                    IDX_W  = $clog2(NUM_REGS);
  localparam int                    STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(NUM_REGS * 4);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, ar_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx, ar_idx;
  logic                  wr_in_range, ar_in_range, ar_hs;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  axi_lite_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_join (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .block_i   (bvalid_q),
    .awaddr_i  (s_axi_awaddr),
    .awvalid_i (s_axi_awvalid),
    .awready_o (s_axi_awready),
    .wdata_i   (s_axi_wdata),
    .wstrb_i   (s_axi_wstrb),
    .wvalid_i  (s_axi_wvalid),
    .wready_o  (s_axi_wready),
    .commit_o  (commit),
    .addr_o    (wr_addr),
    .data_o    (wr_data),
    .strb_o    (wr_strb)
  );

  assign wr_off      = wr_addr - BASE_ADDR;
  assign ar_off      = s_axi_araddr - BASE_ADDR;
  assign wr_in_range = wr_off < SPAN;
  assign ar_in_range = ar_off < SPAN;
  assign wr_idx      = IDX_W'(addr_to_index(64'(wr_addr), IDX_W));
  assign ar_idx      = IDX_W'(addr_to_index(64'(s_axi_araddr), IDX_W));

  assign s_axi_arready = !ARESET && !rvalid_q;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
      pulse_d[wr_idx] = 1'b1;
    end
  end

  // The read samples regs_q, so a same-edge write to that register is not yet visible.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q   <= '{default: '0};
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_in_range ? regs_q[ar_idx] : '0;
        rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
  end

  assign wr_pulse_o   = pulse_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios plus random traffic against a register-array model.
module tb_axi_lite_reg_slave;

  localparam int NR = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [31:0]   s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [2:0]    s_axi_awprot, s_axi_arprot;
  logic [3:0]    s_axi_wstrb;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [NR];

  axi_lite_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- reference model ----------------
  function automatic bit in_range(input logic [31:0] a);
    return (a - BASE) < 32'(NR * 4);
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic model_write(input logic [31:0] a, d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
    int i;
    pulse = '0;
    if (in_range(a)) begin
      i = int'((a - BASE) / 4);
      for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
      pulse[i] = 1'b1;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    if (in_range(a)) begin
      d = model[int'((a - BASE) / 4)];
      resp = 2'b00;
    end else begin
      d = 32'h0;
      resp = 2'b10;
    end
  endtask

  // ---------------- bus drivers (no checking) ----------------
  task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s, input int aw_dly, w_dly,
                           output logic [1:0] resp, output logic [NR-1:0] pulse, output int lat,
                           output bit lingering);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    cyc = 0; aw_done = 0; w_done = 0; lat = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge ACLK);
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) lat = -1;
    while (lat >= 0 && !s_axi_bvalid && lat < 20) begin @(negedge ACLK); lat++; end
    resp = s_axi_bresp; pulse = wr_pulse_o;
    @(negedge ACLK);
    lingering = (|wr_pulse_o) || s_axi_bvalid;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int cyc;
    cyc = 0; lat = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    while (!s_axi_arready && cyc < 20) begin @(negedge ACLK); cyc++; end
    @(negedge ACLK);
    s_axi_arvalid = 1'b0;
    while (!s_axi_rvalid && lat < 20) begin @(negedge ACLK); lat++; end
    d = s_axi_rdata; resp = s_axi_rresp;
    @(negedge ACLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_handshake got aw/w/ar/b/r=%b want 00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    n_checks++;
    if (regs_o !== '0 || wr_pulse_o !== '0 || s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state got regs=%h pulse=%b bresp=%b rresp=%b rdata=%h want all zero",
               regs_o, wr_pulse_o, s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    ARESET = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    @(negedge ACLK);
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_errors++;
      $display("FAIL post_reset_ready got aw/w/ar=%b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_basic_writes();
    logic [31:0] vals [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse; int lat; bit ling;
    logic [31:0] rd, erd;
    for (int i = 0; i < 4; i++) begin
      axi_write(32'(i * 4), vals[i], 4'hF, 0, 0, resp, pulse, lat, ling);
      model_write(32'(i * 4), vals[i], 4'hF, eresp, epulse);
      n_checks++;
      if (resp !== eresp || pulse !== epulse || lat != 0 || ling) begin
        n_errors++;
        $display("FAIL basic_write%0d got resp=%b pulse=%b lat=%0d linger=%0d want resp=%b pulse=%b lat=0 linger=0",
                 i, resp, pulse, lat, ling, eresp, epulse);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), rd, resp, lat);
      model_read(32'(i * 4), erd, eresp);
      n_checks++;
      if (rd !== erd || resp !== eresp || lat != 0) begin
        n_errors++;
        $display("FAIL basic_read%0d got data=%h resp=%b lat=%0d want data=%h resp=%b lat=0", i, rd, resp, lat, erd, eresp);
      end
    end
    n_checks++;
    if (regs_o !== model_flat()) begin
      n_errors++;
      $display("FAIL basic_regs_o got %h want %h", regs_o, model_flat());
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] eresp; logic [NR-1:0] epulse; int extra;
    s_axi_bready = 1'b1;
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    n_checks++;
    if (s_axi_wready !== 1'b1) begin n_errors++; $display("FAIL wfirst_wready got %b want 1", s_axi_wready); end
    @(negedge ACLK);
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b100) begin
        n_errors++;
        $display("FAIL wfirst_wait%0d got aw/w/b=%b want 100", i, {s_axi_awready, s_axi_wready, s_axi_bvalid});
      end
      @(negedge ACLK);
    end
    s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
    @(negedge ACLK);
    s_axi_awvalid = 1'b0;
    model_write(32'h4, 32'h12345678, 4'hF, eresp, epulse);
    n_checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== eresp || wr_pulse_o !== epulse || regs_o[63:32] !== model[1]) begin
      n_errors++;
      $display("FAIL wfirst_commit got b=%b resp=%b pulse=%b reg1=%h want b=1 resp=%b pulse=%b reg1=%h",
               s_axi_bvalid, s_axi_bresp, wr_pulse_o, regs_o[63:32], eresp, epulse, model[1]);
    end
    extra = 0;
    repeat (4) begin @(negedge ACLK); if (s_axi_bvalid) extra++; end
    n_checks++;
    if (extra != 0) begin n_errors++; $display("FAIL wfirst_single_b got %0d extra bvalid cycles want 0", extra); end
  endtask

  task automatic test_strobes();
    logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse; int lat; bit ling;
    logic [31:0] d [3] = '{32'hDEAD0011, 32'h000000AA, 32'hFFFFFFFF};
    logic [3:0]  s [3] = '{4'hF, 4'b0001, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      axi_write(32'h8, d[i], s[i], 0, 0, resp, pulse, lat, ling);
      model_write(32'h8, d[i], s[i], eresp, epulse);
      n_checks++;
      if (resp !== eresp || pulse !== epulse || lat != 0 || ling || regs_o[95:64] !== model[2]) begin
        n_errors++;
        $display("FAIL strobe%0d got resp=%b pulse=%b lat=%0d reg2=%h want resp=%b pulse=%b lat=0 reg2=%h",
                 i, resp, pulse, lat, regs_o[95:64], eresp, epulse, model[2]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse; int lat; bit ling;
    logic [31:0] rd, erd;
    logic [31:0] addrs [2] = '{32'h10, 32'hFFFF_FFFC};
    for (int i = 0; i < 2; i++) begin
      axi_write(addrs[i], 32'h5A5A5A5A, 4'hF, 0, 0, resp, pulse, lat, ling);
      model_write(addrs[i], 32'h5A5A5A5A, 4'hF, eresp, epulse);
      n_checks++;
      if (resp !== eresp || pulse !== epulse || regs_o !== model_flat()) begin
        n_errors++;
        $display("FAIL oor_write%0d got resp=%b pulse=%b regs=%h want resp=%b pulse=%b regs=%h",
                 i, resp, pulse, regs_o, eresp, epulse, model_flat());
      end
      axi_read(addrs[i], rd, resp, lat);
      model_read(addrs[i], erd, eresp);
      n_checks++;
      if (rd !== erd || resp !== eresp) begin
        n_errors++;
        $display("FAIL oor_read%0d got data=%h resp=%b want data=%h resp=%b", i, rd, resp, erd, eresp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] eresp; logic [NR-1:0] epulse; logic [31:0] erd, d1, d2; logic [1:0] erresp;
    d1 = $urandom; d2 = $urandom;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 32'h0; s_axi_wdata = d1; s_axi_wstrb = 4'hF; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'hC; s_axi_arvalid = 1'b1;
    model_read(32'hC, erd, erresp);
    @(negedge ACLK);
    model_write(32'h0, d1, 4'hF, eresp, epulse);
    s_axi_arvalid = 1'b0;
    s_axi_awaddr = 32'h4; s_axi_wdata = d2;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== eresp || s_axi_rvalid !== 1'b1 || s_axi_rdata !== erd ||
          s_axi_rresp !== erresp || {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
        n_errors++;
        $display("FAIL stall%0d got b=%b bresp=%b r=%b rdata=%h rresp=%b aw/w/ar=%b want b=1 bresp=%b r=1 rdata=%h rresp=%b aw/w/ar=000",
                 i, s_axi_bvalid, s_axi_bresp, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
                 {s_axi_awready, s_axi_wready, s_axi_arready}, eresp, erd, erresp);
      end
      @(negedge ACLK);
    end
    n_checks++;
    if (regs_o !== model_flat()) begin n_errors++; $display("FAIL stall_regs got %h want %h", regs_o, model_flat()); end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge ACLK);
    n_checks++;
    if ({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL stall_release got b/r/aw/w=%b want 0011", {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready});
    end
    @(negedge ACLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    model_write(32'h4, d2, 4'hF, eresp, epulse);
    n_checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== eresp || wr_pulse_o !== epulse) begin
      n_errors++;
      $display("FAIL stall_second got b=%b resp=%b pulse=%b want b=1 resp=%b pulse=%b",
               s_axi_bvalid, s_axi_bresp, wr_pulse_o, eresp, epulse);
    end
    @(negedge ACLK);
    n_checks++;
    if (s_axi_bvalid !== 1'b0 || regs_o !== model_flat()) begin
      n_errors++;
      $display("FAIL stall_done got b=%b regs=%h want b=0 regs=%h", s_axi_bvalid, regs_o, model_flat());
    end
  endtask

  task automatic test_same_edge_rw();
    logic [31:0] old, nv; logic [1:0] eresp; logic [NR-1:0] epulse;
    nv = $urandom;
    old = model[2];
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    s_axi_awaddr = 32'h8; s_axi_wdata = nv; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h8;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge ACLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    model_write(32'h8, nv, 4'hF, eresp, epulse);
    n_checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old || s_axi_bvalid !== 1'b1 || regs_o[95:64] !== model[2]) begin
      n_errors++;
      $display("FAIL same_edge got r=%b rdata=%h b=%b reg2=%h want r=1 rdata=%h b=1 reg2=%h",
               s_axi_rvalid, s_axi_rdata, s_axi_bvalid, regs_o[95:64], old, model[2]);
    end
    @(negedge ACLK);
  endtask

  task automatic test_back_to_back();
    int beats, bad;
    beats = 0; bad = 0;
    s_axi_rready = 1'b1; s_axi_araddr = 32'h4; s_axi_arvalid = 1'b1;
    repeat (8) begin
      @(negedge ACLK);
      if (s_axi_rvalid) begin beats++; if (s_axi_rdata !== model[1]) bad++; end
    end
    s_axi_arvalid = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (beats != 4 || bad != 0) begin
      n_errors++;
      $display("FAIL back_to_back got beats=%0d bad_data=%0d want beats=4 bad_data=0", beats, bad);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, erd; logic [3:0] s; logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse;
    int lat; bit ling;
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, pulse, lat, ling);
        model_write(a, d, s, eresp, epulse);
        n_checks++;
        if (resp !== eresp || pulse !== epulse || lat != 0 || ling || regs_o !== model_flat()) begin
          n_errors++;
          $display("FAIL rand_write%0d a=%h got resp=%b pulse=%b lat=%0d regs=%h want resp=%b pulse=%b lat=0 regs=%h",
                   n, a, resp, pulse, lat, regs_o, eresp, epulse, model_flat());
        end
      end else begin
        axi_read(a, rd, resp, lat);
        model_read(a, erd, eresp);
        n_checks++;
        if (rd !== erd || resp !== eresp || lat != 0) begin
          n_errors++;
          $display("FAIL rand_read%0d a=%h got data=%h resp=%b lat=%0d want data=%h resp=%b lat=0",
                   n, a, rd, resp, lat, erd, eresp);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] resp, eresp; logic [NR-1:0] pulse, epulse; int lat; bit ling; logic [31:0] rd;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 32'h4; s_axi_wdata = 32'h11112222; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h4;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge ACLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    n_checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b11) begin
      n_errors++; $display("FAIL midreset_pending got b/r=%b want 11", {s_axi_bvalid, s_axi_rvalid});
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    n_checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00 || regs_o !== '0 || wr_pulse_o !== '0) begin
      n_errors++;
      $display("FAIL midreset_clear got b/r=%b regs=%h pulse=%b want b/r=00 regs=0 pulse=0",
               {s_axi_bvalid, s_axi_rvalid}, regs_o, wr_pulse_o);
    end
    ARESET = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    @(negedge ACLK);
    axi_write(32'hC, 32'hCAFEF00D, 4'hF, 0, 0, resp, pulse, lat, ling);
    model_write(32'hC, 32'hCAFEF00D, 4'hF, eresp, epulse);
    n_checks++;
    if (resp !== eresp || pulse !== epulse || lat != 0 || regs_o !== model_flat()) begin
      n_errors++;
      $display("FAIL postreset_write got resp=%b pulse=%b lat=%0d regs=%h want resp=%b pulse=%b lat=0 regs=%h",
               resp, pulse, lat, regs_o, eresp, epulse, model_flat());
    end
    axi_read(32'hC, rd, resp, lat);
    n_checks++;
    if (rd !== 32'hCAFEF00D || resp !== 2'b00) begin
      n_errors++; $display("FAIL postreset_read got data=%h resp=%b want data=cafef00d resp=00", rd, resp);
    end
  endtask

  initial begin
    ARESET = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    test_reset();
    test_basic_writes();
    test_w_before_aw();
    test_strobes();
    test_out_of_range();
    test_backpressure();
    test_same_edge_rw();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder (slave) exposing NUM_REGS 32-bit read/write registers to fabric logic. It is the slave-side counterpart of the AXI4-Lite master BFM used in the block-design benches, and sits behind the interconnect in the IP's S00_AXI slot. It accepts write address and write data independently and applies byte strobes. It returns SLVERR for out-of-range addresses and holds every response until the master handshakes it.

Parameters:
DATA_WIDTH, 32, AXI data width (only 32 supported)
ADDR_WIDTH, 32, AXI address width
NUM_REGS, 4, number of registers (power of two, 2..16)
BASE_ADDR, 32'h0, byte base address (must be aligned to NUM_REGS*4)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
regs_o  out  NUM_REGS*32  flat register contents, reg i at [32i+31:32i]
wr_pulse_o  out  NUM_REGS  one-cycle strobe on the cycle reg i is committed

Behaviour:
- Reset (ARESET=1 at a clock edge): all registers 0; awready, wready, bvalid, arready and rvalid are 0; bresp, rresp and rdata are 0; wr_pulse_o is 0; internal AW/W holding flags are cleared. Reset mid-transaction silently drops any pending AW, W, B or R.
- Address decode: index = addr[2+log2(NUM_REGS)-1:2]. In range iff (addr - BASE_ADDR) < NUM_REGS*4. Low 2 address bits are ignored.
- Write channel:
  - awready = !aw_held && !bvalid. AW handshake latches the address and sets aw_held.
  - wready = !w_held && !bvalid. W handshake latches data and strobe and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
  - Commit cycle: the first edge where aw_held and w_held are both set, counting handshakes on that edge as already held, so there is no extra cycle when both arrive together.
  - On commit, if in range, update only the strobed bytes, pulse wr_pulse_o[index] and set bresp=OKAY (00). If out of range, registers are unchanged, no pulse is issued and bresp=SLVERR (10).
  - On commit, bvalid is set and both held flags are cleared.
  - Latency: AW+W in the same cycle gives bvalid 1 cycle later.
  - bvalid is held, with bresp stable, until bready; bvalid clears on that edge.
  - No AW or W is accepted while bvalid=1.
- Read channel:
  - arready = !rvalid.
  - AR handshake: on the next edge rvalid=1, rdata = reg[index] (or 0 if out of range), rresp = OKAY or SLVERR.
  - rdata and rresp are stable while rvalid=1 and rready=0. rvalid clears on rready.
  - Throughput: one read every 2 cycles with rready tied high.
- Simultaneous events:
  - Read and write are independent channels.
  - If a write commit and an AR handshake to the same register occur on the same edge, the read returns the pre-write value.
  - wstrb=0 commits with OKAY, no data change, and still pulses wr_pulse_o.
- regs_o reflects register state combinationally from the flops, with no added latency.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, and an addr_to_index function.
- One natural sub-module, axi_lite_wr_join: holds AW and W independently and emits the commit strobe plus the latched addr, data and strobe. The register array and read path stay in the top.

Test Plan:
- Reset, then write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0x0, 0x4, 0x8, 0xC (AW and W same cycle) -> each bresp=00, bvalid 1 cycle after handshake, wr_pulse_o one-hot; readback matches and regs_o matches.
- W presented 3 cycles before AW to reg1 with value 0x12345678 -> wready handshake first, awready stays high, commit on the AW edge, reg1=0x12345678, exactly one bresp=00.
- reg2=0xDEAD0011, then write 0x000000AA with wstrb=4'b0001 -> reg2=0xDEAD00AA; wstrb=0 -> unchanged, bresp=00, pulse issued.
- Write and read at BASE_ADDR+0x10 (NUM_REGS=4) -> bresp=10, rresp=10, rdata=0, registers unchanged, no wr_pulse.
- bready and rready held low for 5 cycles -> bvalid, bresp, rvalid and rdata stable; awready, wready and arready remain 0; a second AW/W is not accepted until B completes.
- Assert ARESET while bvalid=1 and while rvalid=1 -> next edge: bvalid=rvalid=0, all registers 0; a post-reset write/read of 0xCAFEF00D to reg3 succeeds.
